gtparb: RTL

- Read-side arbiter for NFIFO gtp block FIFOs; owns their give/have handshake.
- Picks a non-empty FIFO in round-robin order and reads exactly one complete block from it. Block length comes from the control word (CW) in the block's first dword.
- Forwards the dwords as one contiguous registered stream with start/end-of-block marks to the memory writer.
- Only one FIFO's give is asserted at any time, so the shared tristate data bus has a single driver.

---
 rtl/gtp_pkg.sv | 24 ++
 rtl/rr_pick.sv | 33 +++
 rtl/gtparb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/gtp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gtp_pkg: control-word field positions and arbiter state encoding     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gtp_pkg;

  localparam int CW_FLAG    = 15;
  localparam int CW_CHAN_HI = 14;
  localparam int CW_CHAN_LO = 9;
  localparam int CW_LEN_HI  = 8;
  localparam int CW_LEN_LO  = 1;
  localparam int CW_ODD     = 0;

  localparam logic [15:0] CW_FILLER = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    BODY  = 2'd2
  } gtp_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick: first set request after i_ptr, searching modulo NFIFO       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NFIFO = 4,
  parameter int PW    = 2
) (
  input  logic [NFIFO-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic             o_found,
  output logic [PW-1:0]    o_idx
);

  logic [PW-1:0] w_k;

  // Walk from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = '0;
    for (int i = NFIFO; i >= 1; i--) begin
      w_k = PW'((int'(i_ptr) + i) % NFIFO);
      if (i_req[w_k]) begin
        o_found = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gtparb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gtparb: round-robin block reader for the gtp FIFOs                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gtparb
  import gtp_pkg::*;
#(
  parameter int NFIFO = 4,
  parameter int TMO   = 1023
) (
  input  logic             gtp_clk,
  input  logic             rst,
  input  logic [NFIFO-1:0] fifo_empty,
  input  logic [NFIFO-1:0] fifo_have,
  output logic [NFIFO-1:0] fifo_give,
  input  logic [31:0]      fifo_dat,
  input  logic             out_rdy,
  output logic [31:0]      out_dat,
  output logic             out_vld,
  output logic             out_sob,
  output logic             out_eob,
  output logic             busy,
  output logic [31:0]      blk_cnt,
  output logic             err_cw,
  output logic             err_tmo
);

  localparam int PW  = $clog2(NFIFO);
  localparam int WCW = $clog2(TMO);
  localparam logic [WCW-1:0] c_WCNT_LAST = WCW'(TMO - 1);

  gtp_state_t     r_state, w_state_nx;
  logic [PW-1:0]  r_ptr, w_ptr_nx;
  logic [PW-1:0]  r_sel, w_sel_nx;
  logic [7:0]     r_rem, w_rem_nx;
  logic [WCW-1:0] r_wcnt, w_wcnt_nx;
  logic [31:0]    r_out_dat, r_blk_cnt;
  logic           r_out_vld, r_out_sob, r_out_eob, r_err_cw, r_err_tmo;
  logic           w_found, w_take, w_flag;
  logic           w_fwd, w_sob, w_eob, w_done, w_cwerr, w_tmo;
  logic [PW-1:0]  w_idx;
  logic [7:0]     w_len;

  rr_pick #(.NFIFO(NFIFO), .PW(PW)) u_pick (
    .i_req   (~fifo_empty),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Gating give with out_rdy in the same cycle means nothing is in flight
  // once the sink drops ready.
  always_comb begin
    fifo_give = '0;
    if ((r_state == PROBE || r_state == BODY) && out_rdy)
      fifo_give[r_sel] = 1'b1;
  end

  assign w_take = fifo_have[r_sel] & fifo_give[r_sel];
  assign w_flag = fifo_dat[CW_FLAG];
  assign w_len  = fifo_dat[CW_LEN_HI:CW_LEN_LO];

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_sel_nx   = r_sel;
    w_rem_nx   = r_rem;
    w_wcnt_nx  = r_wcnt;
    w_fwd      = 1'b0;
    w_sob      = 1'b0;
    w_eob      = 1'b0;
    w_done     = 1'b0;
    w_cwerr    = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_sel_nx   = w_idx;
          w_state_nx = PROBE;
        end
      end
      PROBE: begin
        if (out_rdy) begin
          w_ptr_nx   = r_sel;
          w_state_nx = IDLE;
          if (w_take && w_flag) begin
            w_fwd    = 1'b1;
            w_sob    = 1'b1;
            w_rem_nx = w_len;
            if (w_len == 8'd0) begin
              w_eob  = 1'b1;
              w_done = 1'b1;
            end else begin
              w_ptr_nx   = r_ptr;
              w_wcnt_nx  = '0;
              w_state_nx = BODY;
            end
          end else if (w_take) begin
            w_cwerr = 1'b1;
          end
        end
      end
      BODY: begin
        if (w_take) begin
          w_fwd     = 1'b1;
          w_rem_nx  = r_rem - 8'd1;
          w_wcnt_nx = '0;
          if (r_rem == 8'd1) begin
            w_eob      = 1'b1;
            w_done     = 1'b1;
            w_ptr_nx   = r_sel;
            w_state_nx = IDLE;
          end
        end else if (out_rdy) begin
          if (r_wcnt == c_WCNT_LAST) begin
            w_tmo      = 1'b1;
            w_ptr_nx   = r_sel;
            w_state_nx = IDLE;
          end else begin
            w_wcnt_nx = r_wcnt + 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge gtp_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge gtp_clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= PW'(NFIFO - 1);
      r_sel     <= '0;
      r_rem     <= '0;
      r_wcnt    <= '0;
      r_out_dat <= '0;
      r_out_vld <= 1'b0;
      r_out_sob <= 1'b0;
      r_out_eob <= 1'b0;
      r_blk_cnt <= '0;
      r_err_cw  <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nx;
      r_sel     <= w_sel_nx;
      r_rem     <= w_rem_nx;
      r_wcnt    <= w_wcnt_nx;
      r_out_vld <= w_fwd;
      r_out_sob <= w_sob;
      r_out_eob <= w_eob;
      r_err_cw  <= w_cwerr;
      r_err_tmo <= w_tmo;
      if (w_fwd)  r_out_dat <= fifo_dat;
      if (w_done) r_blk_cnt <= r_blk_cnt + 32'd1;
    end
  end

  assign out_dat = r_out_dat;
  assign out_vld = r_out_vld;
  assign out_sob = r_out_sob;
  assign out_eob = r_out_eob;
  assign blk_cnt = r_blk_cnt;
  assign err_cw  = r_err_cw;
  assign err_tmo = r_err_tmo;
  assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire
